// File: rtl/mul_array_pkg.sv
// ============================================================================
// Module : mul_array_pkg
// Brief  : Shared widths, lane types and the per-lane scale/saturate helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_array_pkg;

  localparam int DEF_KX          = 3;
  localparam int DEF_KY          = 3;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_OUT_SCALE   = 16;
  localparam int DEF_PIPE_STAGES = 2;
  localparam int MAX_W           = 64;

  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_KX-1:0]               row_t;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] res;
  } lane_res_t;

  // Result is valid in its low `ow` bits; ovf flags a scaled value outside ow-bit signed range.
  function automatic lane_res_t lane_scale_sat(input logic signed [MAX_W-1:0] full,
                                               input int unsigned             scale,
                                               input int unsigned             ow,
                                               input logic                    sat);
    logic signed [MAX_W-1:0] scaled;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    lane_res_t               r;
    scaled = full >>> scale;
    hi     = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo     = ~hi;
    r.ovf  = (scaled > hi) || (scaled < lo);
    r.res  = (r.ovf && sat) ? (scaled[MAX_W-1] ? lo : hi) : scaled;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_pipe_stage.sv
// ============================================================================
// Module : mul_pipe_stage
// Brief  : One payload+valid register slot; accepts when empty or draining.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_multiplier_array.sv
// ============================================================================
// Module : pipelined_multiplier_array
// Brief  : KY x KX signed lane multipliers, scaled, behind a PIPE_STAGES-deep
//          valid/ready pipeline with a sticky overflow flag.
//          Build option: MUL_ARRAY_SATURATE_EN clamps overflowing lanes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipelined_multiplier_array
  import mul_array_pkg::*;
#(
  parameter int KX          = DEF_KX,
  parameter int KY          = DEF_KY,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int OUT_SCALE   = DEF_OUT_SCALE,
  parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [KY-1:0][KX*DATA_WIDTH-1:0]    kernel,
  input  logic [KY-1:0][KX*DATA_WIDTH-1:0]    data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [KY-1:0][KX*OUT_WIDTH-1:0]     product,
  output logic                                ovf_flag,
  input  logic                                ovf_clr
);

`ifdef MUL_ARRAY_SATURATE_EN
  localparam logic c_SAT = 1'b1;
`else
  localparam logic c_SAT = 1'b0;
`endif
  localparam int c_PW = KY * KX * OUT_WIDTH;

  logic [PIPE_STAGES:0]           w_v;
  logic [PIPE_STAGES:0]           w_rdy;
  logic [PIPE_STAGES:0][c_PW-1:0] w_pd;
  logic [KY*KX-1:0]               w_lane_ovf;
  logic                           ovf_q, ovf_d;

  for (genvar gy = 0; gy < KY; gy++) begin : g_row
    for (genvar gx = 0; gx < KX; gx++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   w_k;
      logic signed [DATA_WIDTH-1:0]   w_dat;
      logic signed [2*DATA_WIDTH-1:0] w_full;
      lane_res_t                      w_res;
      assign w_k    = kernel[gy][gx*DATA_WIDTH +: DATA_WIDTH];
      assign w_dat  = data[gy][gx*DATA_WIDTH +: DATA_WIDTH];
      assign w_full = w_k * w_dat;
      assign w_res  = lane_scale_sat(MAX_W'(w_full), OUT_SCALE, OUT_WIDTH, c_SAT);
      assign w_lane_ovf[gy*KX+gx]                      = w_res.ovf;
      assign w_pd[0][(gy*KX+gx)*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(w_res.res);
    end
  end

  assign w_v[0]             = in_valid;
  assign w_rdy[PIPE_STAGES] = out_ready;

  for (genvar gs = 0; gs < PIPE_STAGES; gs++) begin : g_stage
    mul_pipe_stage #(.WIDTH(c_PW)) u_stage (
      .clk       (clk),
      .arst      (arst),
      .in_valid  (w_v[gs]),
      .in_data   (w_pd[gs]),
      .in_ready  (w_rdy[gs]),
      .out_valid (w_v[gs+1]),
      .out_data  (w_pd[gs+1]),
      .out_ready (w_rdy[gs+1])
    );
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = w_v[PIPE_STAGES];
  assign product   = w_pd[PIPE_STAGES];
  assign ovf_flag  = ovf_q;

  // Overflow is judged on the accepted beat, so a set beats a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (in_valid && w_rdy[0] && (|w_lane_ovf)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

endmodule

`default_nettype wire
